// File: rtl/data_bus_mem_ctrl.sv
// Data-memory slave on the core data bus: decodes bus requests, steers byte lanes and
// extends read data for a synchronous single-port SRAM with byte write enables.
module data_bus_mem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           data_bus_addr,
    input  logic [1:0]            data_bus_mode,
    input  logic [1:0]            data_bus_reqw,
    input  logic                  data_bus_reqs,
    inout  wire  [31:0]           data_bus_data,
    output logic                  data_bus_ready,
    output logic                  data_bus_fault,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR,
        FAULT
    } state_t;

    localparam logic [1:0] MODE_RD = 2'b01;
    localparam logic [1:0] MODE_WR = 2'b10;
    localparam logic [1:0] W_BYTE  = 2'b00;
    localparam logic [1:0] W_HALF  = 2'b01;
    localparam logic [1:0] W_WORD  = 2'b10;

    state_t                state;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            reqw_q;
    logic                  reqs_q;
    logic [31:0]           rd_data_q;
    logic                  ready_q;
    logic                  fault_q;
    logic                  drive_q;
    logic                  wr_en_q;
    logic [3:0]            we_q;
    logic [31:0]           wdata_q;

    logic                  is_rd;
    logic                  is_wr;
    logic                  misaligned;
    logic                  bad_req;
    logic                  rd_start;
    logic [15:0]           lane;
    logic [31:0]           rd_ext;
    logic                  unused_addr_bits;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign unused_addr_bits = ^data_bus_addr[31:ADDR_WIDTH+2];

    function automatic logic [3:0] write_lanes(input logic [1:0] reqw, input logic [1:0] a);
        logic [3:0] we;
        we = 4'b0000;
        case (reqw)
            W_BYTE:  we = 4'b0001 << a;
            W_HALF:  we = a[1] ? 4'b1100 : 4'b0011;
            W_WORD:  we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] write_data(input logic [1:0] reqw, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (reqw)
            W_BYTE:  r = {4{d[7:0]}};
            W_HALF:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign is_rd      = (data_bus_mode == MODE_RD);
    assign is_wr      = (data_bus_mode == MODE_WR);
    assign misaligned = ((data_bus_reqw == W_HALF) && data_bus_addr[0]) ||
                        ((data_bus_reqw == W_WORD) && (data_bus_addr[1:0] != 2'b00));
    assign bad_req    = (data_bus_reqw == 2'b11) || misaligned;

    // The read strobe is issued straight from the live request so the SRAM data
    // arrives in RD_WAIT; reset_n gates it while reset is held in IDLE.
    assign rd_start   = reset_n && (state == IDLE) && is_rd && !bad_req;

    assign sram_en    = rd_start | wr_en_q;
    assign sram_addr  = rd_start ? data_bus_addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
    assign sram_we    = we_q;
    assign sram_wdata = wdata_q;

    assign data_bus_ready = ready_q;
    assign data_bus_fault = fault_q;
    assign data_bus_data  = drive_q ? rd_data_q : 'z;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise
    // an uncovered path keeps its old value and synthesis infers a latch.
    always_comb begin
        lane   = 16'(sram_rdata >> {addr_q[1:0], 3'b000});
        rd_ext = sram_rdata;
        case (reqw_q)
            W_BYTE:  rd_ext = {{24{reqs_q & lane[7]}}, lane[7:0]};
            W_HALF:  rd_ext = {{16{reqs_q & lane[15]}}, lane[15:0]};
            default: rd_ext = sram_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            reqw_q    <= '0;
            reqs_q    <= 1'b0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            drive_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            we_q      <= '0;
            wdata_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            drive_q <= 1'b0;
            wr_en_q <= 1'b0;
            we_q    <= '0;
            case (state)
                IDLE: begin
                    if (is_rd || is_wr) begin
                        addr_q <= data_bus_addr[ADDR_WIDTH+1:0];
                        reqw_q <= data_bus_reqw;
                        reqs_q <= data_bus_reqs;
                        if (bad_req) begin
                            state     <= FAULT;
                            ready_q   <= 1'b1;
                            fault_q   <= 1'b1;
                            drive_q   <= is_rd;
                            rd_data_q <= '0;
                        end else if (is_rd) begin
                            state <= RD_WAIT;
                        end else begin
                            state   <= WR;
                            ready_q <= 1'b1;
                            wr_en_q <= 1'b1;
                            we_q    <= write_lanes(data_bus_reqw, data_bus_addr[1:0]);
                            wdata_q <= write_data(data_bus_reqw, data_bus_data);
                        end
                    end
                end
                RD_WAIT: begin
                    state     <= RD_DONE;
                    rd_data_q <= rd_ext;
                    ready_q   <= 1'b1;
                    drive_q   <= 1'b1;
                end
                RD_DONE: state <= IDLE;
                WR:      state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_mem_ctrl.sv
// Self-checking bench for data_bus_mem_ctrl: SRAM model, request driver and a
// scoreboard of expected responses popped when the DUT raises ready.
module tb_data_bus_mem_ctrl;

    localparam int AW = 12;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WRM = 2'b10;
    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   addr = '0;
    logic [1:0]    mode = '0;
    logic [1:0]    reqw = '0;
    logic          reqs = 1'b0;
    logic          tb_drive = 1'b0;
    logic [31:0]   tb_wdata = '0;
    wire  [31:0]   data_bus_data;
    logic          ready;
    logic          fault;
    logic [AW-1:0] sram_addr;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = '0;
    logic [31:0]   mem [0:(1<<AW)-1] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        rd;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign data_bus_data = tb_drive ? tb_wdata : 'z;

    data_bus_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_bus_addr  (addr),
        .data_bus_mode  (mode),
        .data_bus_reqw  (reqw),
        .data_bus_reqs  (reqs),
        .data_bus_data  (data_bus_data),
        .data_bus_ready (ready),
        .data_bus_fault (fault),
        .sram_addr      (sram_addr),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_we[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(ready), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "/fault"}, 32'(fault), 32'(mon_e.fault));
                if (mon_e.rd) check({mon_e.tag, "/bus"}, data_bus_data, mon_e.data);
            end
        end
    end

    // For writes exp_data/exp_we are the expected SRAM write data and lanes;
    // for reads exp_data is the expected bus value.
    task automatic do_req(input string tag, input logic [1:0] m, input logic [31:0] a,
                          input logic [1:0] w, input logic s, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic [3:0] exp_we,
                          input logic exp_fault);
        exp_t e;
        int   cyc;
        int   lat;
        logic done;
        e.data  = exp_data;
        e.fault = exp_fault;
        e.rd    = (m == RD);
        e.tag   = tag;
        lat     = (m == RD && !exp_fault) ? 2 : 1;
        sb.push_back(e);
        @(negedge clk);
        mode = m; addr = a; reqw = w; reqs = s; tb_wdata = wd; tb_drive = (m == WRM);
        #1;
        check({tag, "/strobe"}, 32'(sram_en), 32'(m == RD && !exp_fault));
        if (m == RD && !exp_fault)
            check({tag, "/rd_addr"}, 32'(sram_addr), (a >> 2) & 32'hFFF);
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_fault) check({tag, "/no_sram"}, 32'(sram_en), 32'd0);
            if (m == WRM && !exp_fault && cyc == 1) begin
                check({tag, "/wr_en"}, 32'(sram_en), 32'd1);
                check({tag, "/wr_we"}, 32'(sram_we), 32'(exp_we));
                check({tag, "/wr_addr"}, 32'(sram_addr), (a >> 2) & 32'hFFF);
                check({tag, "/wr_data"}, sram_wdata, exp_data);
            end
            if (ready) begin
                done = 1'b1;
                check({tag, "/latency"}, 32'(cyc), 32'(lat));
            end
        end
        if (!done) begin
            check({tag, "/timeout_ready"}, 32'(ready), 32'd1);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(negedge clk);
        mode = 2'b00; tb_drive = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a live read request on the bus.
        mode = RD; addr = 32'h10; reqw = W;
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready", 32'(ready), 32'd0);
        check("rst/fault", 32'(fault), 32'd0);
        check("rst/sram_en", 32'(sram_en), 32'd0);
        check("rst/sram_we", 32'(sram_we), 32'd0);
        check("rst/sram_addr", 32'(sram_addr), 32'd0);
        check("rst/sram_wdata", sram_wdata, 32'd0);
        @(negedge clk);
        mode = 2'b00;
        reset_n = 1'b1;

        do_req("sw_10",  WRM, 32'h10, W, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0);
        do_req("lw_10",  RD,  32'h10, W, 0, 32'h0, 32'hDEADBEEF, 4'b0, 0);
        do_req("sw_20",  WRM, 32'h20, W, 0, 32'h80FF7F01, 32'h80FF7F01, 4'b1111, 0);
        do_req("lb_23",  RD,  32'h23, B, 1, 32'h0, 32'hFFFFFF80, 4'b0, 0);
        do_req("lbu_23", RD,  32'h23, B, 0, 32'h0, 32'h00000080, 4'b0, 0);
        do_req("lb_20",  RD,  32'h20, B, 1, 32'h0, 32'h00000001, 4'b0, 0);
        do_req("lb_21",  RD,  32'h21, B, 1, 32'h0, 32'h0000007F, 4'b0, 0);
        do_req("lh_22",  RD,  32'h22, H, 1, 32'h0, 32'hFFFF80FF, 4'b0, 0);
        do_req("lhu_20", RD,  32'h20, H, 0, 32'h0, 32'h00007F01, 4'b0, 0);
        do_req("sh_06",  WRM, 32'h06, H, 0, 32'h1234ABCD, 32'hABCDABCD, 4'b1100, 0);
        do_req("lh_06",  RD,  32'h06, H, 1, 32'h0, 32'hFFFFABCD, 4'b0, 0);
        do_req("lhu_06", RD,  32'h06, H, 0, 32'h0, 32'h0000ABCD, 4'b0, 0);
        do_req("lw_04",  RD,  32'h04, W, 0, 32'h0, 32'hABCD0000, 4'b0, 0);
        do_req("sb_11",  WRM, 32'h11, B, 0, 32'hFFFFFF5A, 32'h5A5A5A5A, 4'b0010, 0);
        do_req("lw_10b", RD,  32'h10, W, 0, 32'h0, 32'hDEAD5AEF, 4'b0, 0);
        do_req("lw_wrap", RD, 32'h00004010, W, 0, 32'h0, 32'hDEAD5AEF, 4'b0, 0);

        do_req("flt_lw_02",  RD,  32'h02, W, 0, 32'h0, 32'h0, 4'b0, 1);
        do_req("flt_lh_01",  RD,  32'h01, H, 1, 32'h0, 32'h0, 4'b0, 1);
        do_req("flt_reqw11", RD,  32'h00, 2'b11, 0, 32'h0, 32'h0, 4'b0, 1);
        do_req("flt_sw_03",  WRM, 32'h03, W, 0, 32'h55555555, 32'h0, 4'b0, 1);
        do_req("flt_sh_05",  WRM, 32'h05, H, 0, 32'h55555555, 32'h0, 4'b0, 1);
        do_req("lw_10c", RD,  32'h10, W, 0, 32'h0, 32'hDEAD5AEF, 4'b0, 0);

        // Reset pulsed while a read sits in RD_WAIT.
        @(negedge clk);
        mode = RD; addr = 32'h10; reqw = W; reqs = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_rd/ready", 32'(ready), 32'd0);
        @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_rd/no_ready", 32'(ready), 32'd0);

        // Reset pulsed while a write sits in WR: it must not commit.
        @(negedge clk);
        mode = WRM; addr = 32'h10; reqw = W; tb_wdata = 32'h11111111; tb_drive = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_wr/sram_en", 32'(sram_en), 32'd0);
        @(negedge clk);
        mode = 2'b00; tb_drive = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        do_req("lw_after_abort", RD, 32'h10, W, 0, 32'h0, 32'hDEAD5AEF, 4'b0, 0);
        do_req("sw_30", WRM, 32'h30, W, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 0);
        do_req("lw_30", RD,  32'h30, W, 0, 32'h0, 32'hCAFEF00D, 4'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
